// File: rtl/symbol_bit_collector.sv
// Packs one OFDM symbol of demapped hard bits (one data subcarrier per cycle)
// into a single Ncbps-wide word and holds it until the deinterleaver takes it.
module symbol_bit_collector #(
  parameter int N_SD      = 48,
  parameter int MAX_NBPSC = 6,
  parameter int OUT_W     = 289
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mod,
  input  logic                 sym_abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_NBPSC-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     sym_bits,
  output logic [8:0]           out_ncbps
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_ready depends on state only, out_valid is held until out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       sc_cnt_q, sc_cnt_d;
  logic [8:0]       wr_ptr_q, wr_ptr_d;
  logic [2:0]       nbpsc_q, nbpsc_d;
  logic [8:0]       ncbps_q, ncbps_d;
  logic [8:0]       out_ncbps_q, out_ncbps_d;
  logic [OUT_W-1:0] sym_q, sym_d;

  logic [2:0] mod_nbpsc;
  logic       accept;
  logic       do_write;
  logic [8:0] wr_base;
  logic [2:0] wr_nb;

  always_comb begin
    case (mod)
      2'd0:    mod_nbpsc = 3'd1;
      2'd1:    mod_nbpsc = 3'd2;
      2'd2:    mod_nbpsc = 3'd4;
      default: mod_nbpsc = 3'd6;
    endcase
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign sym_bits  = sym_q;
  assign out_ncbps = out_ncbps_q;

  always_comb begin
    state_d     = state_q;
    sc_cnt_d    = sc_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    nbpsc_d     = nbpsc_q;
    ncbps_d     = ncbps_q;
    out_ncbps_d = out_ncbps_q;
    sym_d       = sym_q;
    do_write    = 1'b0;
    wr_base     = wr_ptr_q;
    wr_nb       = nbpsc_q;

    case (state_q)
      IDLE: begin
        if (sym_abort) begin
          sc_cnt_d = 6'd0;
          wr_ptr_d = 9'd0;
        end else if (accept) begin
          // Symbol start: modulation is latched here and only here.
          nbpsc_d  = mod_nbpsc;
          ncbps_d  = 9'(N_SD) * {6'd0, mod_nbpsc};
          sym_d    = '0;
          do_write = 1'b1;
          wr_base  = 9'd0;
          wr_nb    = mod_nbpsc;
          sc_cnt_d = 6'd1;
          wr_ptr_d = {6'd0, mod_nbpsc};
          state_d  = FILL;
        end
      end
      FILL: begin
        if (sym_abort) begin
          state_d  = IDLE;
          sc_cnt_d = 6'd0;
          wr_ptr_d = 9'd0;
        end else if (accept) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_q + {6'd0, nbpsc_q};
          sc_cnt_d = sc_cnt_q + 6'd1;
          if (sc_cnt_q == 6'(N_SD - 1)) begin
            state_d     = HOLD;
            out_ncbps_d = ncbps_q;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = IDLE;
          sc_cnt_d = 6'd0;
          wr_ptr_d = 9'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_write) begin
      for (int b = 0; b < MAX_NBPSC; b++) begin
        if (3'(b) < wr_nb) sym_d[wr_base + 9'(b)] = in_bits[b];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sc_cnt_q    <= 6'd0;
      wr_ptr_q    <= 9'd0;
      nbpsc_q     <= 3'd1;
      ncbps_q     <= 9'd0;
      out_ncbps_q <= 9'd0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      sc_cnt_q    <= sc_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      nbpsc_q     <= nbpsc_d;
      ncbps_q     <= ncbps_d;
      out_ncbps_q <= out_ncbps_d;
      sym_q       <= sym_d;
    end
  end

endmodule

// File: tb/tb_symbol_bit_collector.sv
// Bench for symbol_bit_collector: directed sequence of symbols with random
// payloads, compared against a packing model built from the subcarrier list.
module tb_symbol_bit_collector;

  localparam int N_SD  = 48;
  localparam int OUT_W = 289;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       mod = 2'd0;
  logic             sym_abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_bits = 6'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] sym_bits;
  logic [8:0]       out_ncbps;

  int vectors = 0;
  int miscompares = 0;
  logic [OUT_W-1:0] exp_q[$];

  symbol_bit_collector dut (
    .clk       (clk),
    .reset     (reset),
    .mod       (mod),
    .sym_abort (sym_abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sym_bits  (sym_bits),
    .out_ncbps (out_ncbps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbpsc_of(input logic [1:0] m);
    return (m == 2'd3) ? 6 : (1 << m);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_sc(input logic [5:0] bits);
    int guard = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {288'd0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_bits  = 6'($urandom);
  endtask

  // pat: 0 random, 1 alternating bit0 starting at 1, 2 counting n
  task automatic run_symbol(input logic [1:0] m, input int pat,
                            input int switch_at, input bit do_handshake);
    logic [5:0]       sc[N_SD];
    logic [OUT_W-1:0] w;
    int               nb;
    nb = nbpsc_of(m);
    for (int n = 0; n < N_SD; n++) begin
      case (pat)
        1:       sc[n] = {5'($urandom), (n % 2 == 0)};
        2:       sc[n] = 6'(n);
        default: sc[n] = 6'($urandom);
      endcase
    end
    w = '0;
    for (int n = 0; n < N_SD; n++)
      for (int b = 0; b < nb; b++)
        w[n * nb + b] = sc[n][b];
    exp_q.push_back(w);

    mod = m;
    for (int n = 0; n < N_SD; n++) begin
      if (n == switch_at) mod = 2'd0;
      if (n == N_SD - 1) check("valid_before_last", {288'd0, out_valid}, 0);
      send_sc(sc[n]);
      if (n < N_SD - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("valid_after_last", {288'd0, out_valid}, 1);
    check("ready_in_hold", {288'd0, in_ready}, 0);
    check("ncbps", {280'd0, out_ncbps}, OUT_W'(N_SD * nb));
    check("sym_bits", sym_bits, exp_q.pop_front());
    check("bit288", {288'd0, sym_bits[288]}, 0);
    if (do_handshake) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_after_hs", {288'd0, out_valid}, 0);
      check("ready_after_hs", {288'd0, in_ready}, 1);
    end
  endtask

  initial begin
    logic [OUT_W-1:0] held;
    logic [47:0]      alt_pat;

    // Reset state
    #12;
    check("rst_valid", {288'd0, out_valid}, 0);
    check("rst_ready", {288'd0, in_ready}, 1);
    check("rst_bits", sym_bits, 0);
    check("rst_ncbps", {280'd0, out_ncbps}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // BPSK alternating
    alt_pat = 48'h5555_5555_5555;
    run_symbol(2'd0, 1, -1, 1'b0);
    check("bpsk_low48", {241'd0, sym_bits[47:0]}, {241'd0, alt_pat});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bpsk_hs_valid", {288'd0, out_valid}, 0);
    check("bits_kept_after_hs", {241'd0, sym_bits[47:0]}, {241'd0, alt_pat});

    // 64-QAM counting
    run_symbol(2'd3, 2, -1, 1'b1);

    // Backpressure on QPSK, with in_valid and sym_abort pushed during HOLD
    run_symbol(2'd1, 0, -1, 1'b0);
    held = sym_bits;
    for (int i = 0; i < 10; i++) begin
      in_valid  = (i % 2 == 0);
      sym_abort = (i == 4);
      in_bits   = 6'($urandom);
      @(negedge clk);
      check("bp_valid", {288'd0, out_valid}, 1);
      check("bp_ready", {288'd0, in_ready}, 0);
      check("bp_stable", sym_bits, held);
      check("bp_ncbps", {280'd0, out_ncbps}, 96);
    end
    in_valid  = 1'b0;
    sym_abort = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", {288'd0, out_valid}, 0);
    check("bp_release_ready", {288'd0, in_ready}, 1);

    // 16-QAM with mod switched to BPSK after subcarrier 10
    run_symbol(2'd2, 0, 11, 1'b1);

    // Abort after 20 subcarriers of 64-QAM
    mod = 2'd3;
    for (int n = 0; n < 20; n++) send_sc(6'($urandom));
    in_valid  = 1'b1;
    sym_abort = 1'b1;
    in_bits   = 6'h3f;
    @(negedge clk);
    in_valid  = 1'b0;
    sym_abort = 1'b0;
    check("abort_valid", {288'd0, out_valid}, 0);
    check("abort_ready", {288'd0, in_ready}, 1);
    run_symbol(2'd0, 0, -1, 1'b1);

    // Async reset while holding a symbol
    run_symbol(2'd1, 0, -1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", {288'd0, out_valid}, 0);
    check("areset_ready", {288'd0, in_ready}, 1);
    check("areset_bits", sym_bits, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_symbol(2'd0, 0, -1, 1'b1);

    // Random modulations back to back
    for (int k = 0; k < 4; k++) run_symbol(2'($urandom_range(0, 3)), 0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/symbol_bit_collector.md
Name: symbol_bit_collector

Overview:
- Sits directly upstream of the per-symbol deinterleaver stage.
- Accepts demapped hard bits from the demapper one data subcarrier per cycle and packs one complete OFDM symbol into a parallel word of Ncbps bits.
- Presents the word with its Ncbps value over a valid/ready handshake, which is the deinterleaver's m / Ncbps input format.
- Single symbol buffer with an explicit fill/hold state machine; a symbol abort lets the receiver discard a partial symbol.

Parameters:
- N_SD, 48, data subcarriers per OFDM symbol.
- MAX_NBPSC, 6, maximum coded bits per subcarrier (64-QAM).
- OUT_W, 289, output word width; matches the deinterleaver input bus; bit 288 is always 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mod  input  2  modulation: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled only at symbol start.
- sym_abort  input  1  discard any partial symbol; ignored in HOLD.
- in_valid  input  1  in_bits carries one subcarrier.
- in_ready  output  1  collector can accept a subcarrier.
- in_bits  input  MAX_NBPSC  subcarrier bits, LSB-aligned; bit 0 is the first bit in time; unused upper bits ignored.
- out_valid  output  1  sym_bits holds a complete symbol.
- out_ready  input  1  downstream accepts the symbol.
- sym_bits  output  OUT_W  packed symbol bits.
- out_ncbps  output  9  Ncbps of the held symbol: 48, 96, 192 or 288.

Behaviour:
- Reset (reset=0, asynchronous) forces all of the following; release is synchronous to clk:
  - state=IDLE, sc_cnt=0, wr_ptr=0.
  - sym_bits=0, out_ncbps=0, out_valid=0, latched nbpsc=1.
- Nbpsc mapping from mod: 0→1, 1→2, 2→4, 3→6. Ncbps = N_SD*Nbpsc, computed in 9 bits with no overflow (max 288).
- in_ready is 1 in IDLE and FILL, 0 in HOLD. It is driven combinationally from state only, never from in_valid or out_ready.
- A subcarrier is accepted on a cycle with in_valid=1 and in_ready=1.
- IDLE:
  - On accept: latch nbpsc and ncbps from mod, clear sym_bits, then write subcarrier 0.
  - Set sc_cnt=1, wr_ptr=nbpsc and go to FILL.
- FILL:
  - On accept: write sym_bits[wr_ptr+b]=in_bits[b] for b=0..nbpsc-1.
  - Then wr_ptr+=nbpsc and sc_cnt+=1.
  - Changes on mod during FILL are ignored.
- Completion:
  - When the accepted subcarrier has sc_cnt==N_SD-1, go to HOLD.
  - On the next cycle out_valid=1 and out_ncbps=latched ncbps.
  - Latency from the 48th accept edge to out_valid is 1 cycle.
- Packing rule: subcarrier n, bit b lands at sym_bits[n*nbpsc+b]. Bits at index ≥ ncbps are 0, as is bit 288.
- HOLD:
  - sym_bits and out_ncbps stay stable while out_valid=1 and out_ready=0.
  - When out_valid=1 and out_ready=1: out_valid=0, go to IDLE, sc_cnt=0, wr_ptr=0. sym_bits keeps its value until the next symbol start.
  - Minimum of 1 bubble cycle between symbols; in_ready rises the cycle after the output handshake.
- sym_abort:
  - In IDLE or FILL: return to IDLE with sc_cnt=0 and wr_ptr=0.
  - It takes priority over a simultaneous accept; that subcarrier is dropped.
  - In HOLD it has no effect; the completed symbol is still delivered.
- in_valid=0 during FILL stalls with no state change; no timeout.
- Reset mid-FILL or in HOLD: the partial or held symbol is lost and out_valid drops immediately (asynchronously).

Test Plan:
- Reset then BPSK: mod=0, 48 subcarriers with in_bits[0] alternating 1,0,… → out_valid 1 cycle after the 48th accept. sym_bits[47:0]=0x5555_5555_5555, all higher bits 0, out_ncbps=48.
- 64-QAM: mod=3, subcarrier n carries in_bits=n[5:0] → sym_bits[6n+5:6n]=n for n=0..47, out_ncbps=288, sym_bits[288]=0.
- Backpressure: complete a QPSK symbol with out_ready=0 for 10 cycles → in_ready=0, sym_bits stable throughout. Raise out_ready → out_valid falls next cycle; in_ready=1 that same cycle.
- Mid-symbol mod change: start 16-QAM, switch mod to 0 after subcarrier 10 → packing still 4 bits per subcarrier, out_ncbps=192.
- Abort: feed 20 subcarriers, pulse sym_abort together with in_valid → subcarrier dropped. The next 48 subcarriers form a clean symbol starting at bit 0; stale bits are cleared.
- Async reset in HOLD: assert reset between clock edges → out_valid=0 and in_ready=1 without a clock edge. After release, a fresh BPSK symbol completes normally.
